// File: rtl/vga_scanout_pkg.sv
// rtl/vga_scanout_pkg.sv - shared 640x480@60 timing defaults, counter and colour types
package vga_scanout_pkg;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 20;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb_t;

    function automatic logic in_range(input cnt_t v, input cnt_t lo, input cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_scanout_counter.sv
// rtl/vga_scanout_counter.sv - horizontal/vertical raster counters with end-of-line/frame wrap
module vga_scanout_counter
    import vga_scanout_pkg::*;
#(
    parameter cnt_t H_TOTAL = cnt_t'(H_TOTAL_DEF),
    parameter cnt_t V_TOTAL = cnt_t'(V_TOTAL_DEF)
) (
    input  logic clk,
    input  logic rst,
    output cnt_t hcnt,
    output cnt_t vcnt
);

    localparam cnt_t H_LAST = H_TOTAL - cnt_t'(1);
    localparam cnt_t V_LAST = V_TOTAL - cnt_t'(1);

    cnt_t hcnt_q, hcnt_d;
    cnt_t vcnt_q, vcnt_d;
    logic eol;
    logic eof;

    always_comb begin
        eol    = (hcnt_q == H_LAST);
        eof    = eol && (vcnt_q == V_LAST);
        hcnt_d = eol ? '0 : hcnt_q + cnt_t'(1);
        vcnt_d = vcnt_q;
        if (eof) begin
            vcnt_d = '0;
        end else if (eol) begin
            vcnt_d = vcnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt = hcnt_q;
    assign vcnt = vcnt_q;

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - raster scan engine: pixel address out, registered colour and sync to pins
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] addr,
    input  logic [2:0]        ired,
    input  logic [2:0]        igreen,
    input  logic [2:0]        iblue,
    output logic [2:0]        vga_r,
    output logic [2:0]        vga_g,
    output logic [2:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vblank,
    output logic              frame_tick
);

    localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
    localparam cnt_t H_TOTAL  = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
    localparam cnt_t V_TOTAL  = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    cnt_t hcnt;
    cnt_t vcnt;

    vga_scanout_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .hcnt (hcnt),
        .vcnt (vcnt)
    );

    logic visible0;
    logic hs0;
    logic vs0;

    rgb_t rgb_q, rgb_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic vblank_q, vblank_d;
    logic frame_tick_q, frame_tick_d;

    // Stage 0 decode; everything below is registered once so colour and sync stay aligned.
    always_comb begin
        visible0     = (hcnt < H_VIS) && (vcnt < V_VIS);
        hs0          = !in_range(hcnt, HS_START, HS_END);
        vs0          = !in_range(vcnt, VS_START, VS_END);
        rgb_d        = visible0 ? rgb_t'{r: ired, g: igreen, b: iblue} : '0;
        hs_d         = hs0;
        vs_d         = vs0;
        vblank_d     = (vcnt >= V_VIS);
        frame_tick_d = (hcnt == '0) && (vcnt == V_VIS);
    end

    assign addr = visible0 ? {1'b0, hcnt, vcnt[8:0]} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q        <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            vblank_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            rgb_q        <= rgb_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            vblank_q     <= vblank_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga_r      = rgb_q.r;
    assign vga_g      = rgb_q.g;
    assign vga_b      = rgb_q.b;
    assign vga_hs     = hs_q;
    assign vga_vs     = vs_q;
    assign vblank     = vblank_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed bench: full-size line timing plus a shrunken raster for frame behaviour
module tb_vga_scanout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_s = 1'b1;

    logic [19:0] addr, addr_s;
    logic [2:0]  vga_r, vga_g, vga_b;
    logic [2:0]  vga_r_s, vga_g_s, vga_b_s;
    logic        vga_hs, vga_vs, vblank, frame_tick;
    logic        vga_hs_s, vga_vs_s, vblank_s, frame_tick_s;

    logic [2:0]  c101;
    logic [2:0]  sr, sg, sb;

    int checks = 0;
    int errors = 0;
    int ts = 0;

    always #5 clk = ~clk;

    // Colour lookup models: constant 3'b101 for the full-size part, r=x[2:0] g=y[2:0] b=3 for the small one.
    assign c101 = 3'b101;
    assign sr   = addr_s[11:9];
    assign sg   = addr_s[2:0];
    assign sb   = 3'd3;

    vga_scanout dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .ired       (c101),
        .igreen     (c101),
        .iblue      (c101),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vblank     (vblank),
        .frame_tick (frame_tick)
    );

    // 25 x 15 raster: hsync low hcnt 18..21, vsync low lines 10..11, vblank lines 8..14, frame 375 clocks.
    vga_scanout #(
        .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (3),
        .V_VISIBLE (8),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
    ) dut_s (
        .clk        (clk),
        .rst        (rst_s),
        .addr       (addr_s),
        .ired       (sr),
        .igreen     (sg),
        .iblue      (sb),
        .vga_r      (vga_r_s),
        .vga_g      (vga_g_s),
        .vga_b      (vga_b_s),
        .vga_hs     (vga_hs_s),
        .vga_vs     (vga_vs_s),
        .vblank     (vblank_s),
        .frame_tick (frame_tick_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        ts++;
    endtask

    task automatic adv(input int target);
        while (ts < target) tick();
    endtask

    function automatic logic [19:0] pix(input int x, input int y);
        logic [9:0] xv;
        logic [8:0] yv;
        xv = 10'(x);
        yv = 9'(y);
        return {1'b0, xv, yv};
    endfunction

    initial begin
        int x, xs, ys, hs_low, first_low, vbl_hi, ft_cnt;

        @(negedge clk);
        repeat (3) tick();
        check("rst_addr",  addr, 20'h0);
        check("rst_rgb",   {vga_r, vga_g, vga_b}, 9'h0);
        check("rst_hs",    vga_hs, 1'b1);
        check("rst_vs",    vga_vs, 1'b1);
        check("rst_vblank", vblank, 1'b0);
        check("rst_tick",  frame_tick, 1'b0);
        check("rst_s_hs",  vga_hs_s, 1'b1);
        check("rst_s_vs",  vga_vs_s, 1'b1);

        // Two full-size lines of constant colour.
        rst = 1'b0;
        check("addr_t0", addr, pix(0, 0));
        hs_low    = 0;
        first_low = -1;
        for (int k = 1; k <= 1600; k++) begin
            tick();
            x  = (k - 1) % 800;
            xs = k % 800;
            ys = k / 800;
            check("line_rgb", {vga_r, vga_g, vga_b}, (x < 640) ? 9'b101_101_101 : 9'h0);
            check("line_hs", vga_hs, (x >= 656 && x <= 751) ? 1'b0 : 1'b1);
            check("line_addr", addr, (xs < 640) ? pix(xs, ys) : 20'h0);
            if (!vga_hs) hs_low++;
            if (!vga_hs && first_low < 0) first_low = k;
        end
        check("hs_low_clocks", hs_low, 192);
        check("hs_first_low", first_low, 657);
        check("line_vs", vga_vs, 1'b1);
        check("line_vblank", vblank, 1'b0);

        // Small raster: one full frame.
        rst_s  = 1'b0;
        ts     = 0;
        vbl_hi = 0;
        ft_cnt = 0;
        check("s_addr_t0", addr_s, pix(0, 0));
        while (ts < 375) begin
            tick();
            if (vblank_s) vbl_hi++;
            if (frame_tick_s) ft_cnt++;
            if (ts == 11)  check("s_pix_10_0", {vga_r_s, vga_g_s, vga_b_s}, {3'd2, 3'd0, 3'd3});
            if (ts == 18)  check("s_hs_pre", vga_hs_s, 1'b1);
            if (ts == 19)  check("s_hs_first", vga_hs_s, 1'b0);
            if (ts == 22)  check("s_hs_last", vga_hs_s, 1'b0);
            if (ts == 23)  check("s_hs_post", vga_hs_s, 1'b1);
            if (ts == 26)  check("s_pix_0_1", {vga_r_s, vga_g_s, vga_b_s}, {3'd0, 3'd1, 3'd3});
            if (ts == 190) check("s_addr_15_7", addr_s, pix(15, 7));
            if (ts == 191) check("s_pix_15_7", {vga_r_s, vga_g_s, vga_b_s}, {3'd7, 3'd7, 3'd3});
            if (ts == 200) check("s_vblank_pre", vblank_s, 1'b0);
            if (ts == 201) check("s_vblank_rise", vblank_s, 1'b1);
            if (ts == 201) check("s_tick_rise", frame_tick_s, 1'b1);
            if (ts == 201) check("s_blank_rgb", {vga_r_s, vga_g_s, vga_b_s}, 9'h0);
            if (ts == 202) check("s_tick_fall", frame_tick_s, 1'b0);
            if (ts == 250) check("s_vs_pre", vga_vs_s, 1'b1);
            if (ts == 251) check("s_vs_first", vga_vs_s, 1'b0);
            if (ts == 300) check("s_vs_last", vga_vs_s, 1'b0);
            if (ts == 301) check("s_vs_post", vga_vs_s, 1'b1);
            if (ts == 374) check("s_addr_end", addr_s, 20'h0);
        end
        check("s_vblank_end", vblank_s, 1'b1);
        check("s_vblank_clocks", vbl_hi, 175);
        check("s_tick_count", ft_cnt, 1);

        // Frame wrap: (24,14) -> (0,0) -> line 1.
        tick();
        check("s_wrap_vblank", vblank_s, 1'b0);
        check("s_wrap_rgb", {vga_r_s, vga_g_s, vga_b_s}, {3'd0, 3'd0, 3'd3});
        check("s_wrap_addr", addr_s, pix(1, 0));
        adv(401);
        check("s_line1_addr", addr_s, pix(1, 1));
        adv(575);
        check("s_tick2_pre", frame_tick_s, 1'b0);
        tick();
        check("s_tick2", frame_tick_s, 1'b1);

        // Reset while both syncs are low.
        adv(670);
        check("s_mid_hs_low", vga_hs_s, 1'b0);
        check("s_mid_vs_low", vga_vs_s, 1'b0);
        rst_s = 1'b1;
        tick();
        check("s_mrst_hs", vga_hs_s, 1'b1);
        check("s_mrst_vs", vga_vs_s, 1'b1);
        check("s_mrst_addr", addr_s, 20'h0);
        check("s_mrst_rgb", {vga_r_s, vga_g_s, vga_b_s}, 9'h0);
        check("s_mrst_vblank", vblank_s, 1'b0);
        rst_s = 1'b0;
        ts    = 0;
        tick();
        check("s_restart_addr", addr_s, pix(1, 0));
        check("s_restart_rgb", {vga_r_s, vga_g_s, vga_b_s}, {3'd0, 3'd0, 3'd3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
